// File: rtl/seg_decode_clkgen_if.sv
// Panel-side bundle for seg_decode_clkgen: symbol code in, segment pattern and timing waves out.
interface seg_decode_clkgen_if;
  logic [3:0] BCD;
  logic [6:0] DISPLAY;
  logic       CLK_1Hz;
  logic       CLK_2Hz;
  logic       CLK_1KHz;

  modport master (
    output BCD,
    input  DISPLAY,
    input  CLK_1Hz,
    input  CLK_2Hz,
    input  CLK_1KHz
  );

  modport slave (
    input  BCD,
    output DISPLAY,
    output CLK_1Hz,
    output CLK_2Hz,
    output CLK_1KHz
  );
endinterface

// File: rtl/seg_decode_clkgen.sv
// Active-low 7-segment decoder plus 1 Hz / 2 Hz / 1 kHz square-wave dividers.
// Optional letter set for codes 10-15 is enabled by defining SEG_LETTERS_EN.
module seg_decode_clkgen #(
  parameter int CLK_HZ = 100_000_000
) (
  input logic            CLK,
  input logic            RST_N,
  seg_decode_clkgen_if.slave bus
);

  localparam int H1K = CLK_HZ / 2000;
  localparam int H2  = CLK_HZ / 4;
  localparam int H1  = CLK_HZ / 2;

  // Each counter only needs to reach H-1 of its own output.
  localparam int W1K = (H1K > 1) ? $clog2(H1K) : 1;
  localparam int W2  = (H2  > 1) ? $clog2(H2)  : 1;
  localparam int W1  = (H1  > 1) ? $clog2(H1)  : 1;

  localparam logic [W1K-1:0] TC1K = W1K'(H1K - 1);
  localparam logic [W2-1:0]  TC2  = W2'(H2 - 1);
  localparam logic [W1-1:0]  TC1  = W1'(H1 - 1);

  logic [W1K-1:0] cnt_1k;
  logic [W2-1:0]  cnt_2;
  logic [W1-1:0]  cnt_1;
  logic           wave_1k;
  logic           wave_2;
  logic           wave_1;
  logic [6:0]     seg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_1k  <= '0;
      wave_1k <= 1'b0;
    end else if (cnt_1k == TC1K) begin
      cnt_1k  <= '0;
      wave_1k <= ~wave_1k;
    end else begin
      cnt_1k  <= cnt_1k + W1K'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_2  <= '0;
      wave_2 <= 1'b0;
    end else if (cnt_2 == TC2) begin
      cnt_2  <= '0;
      wave_2 <= ~wave_2;
    end else begin
      cnt_2  <= cnt_2 + W2'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_1  <= '0;
      wave_1 <= 1'b0;
    end else if (cnt_1 == TC1) begin
      cnt_1  <= '0;
      wave_1 <= ~wave_1;
    end else begin
      cnt_1  <= cnt_1 + W1'(1);
    end
  end

  // Bit order {a,b,c,d,e,f,g}; a zero lights the segment.
  always_comb begin
    seg = 7'b1111110;
    case (bus.BCD)
      4'd0:  seg = 7'b0000001;
      4'd1:  seg = 7'b1001111;
      4'd2:  seg = 7'b0010010;
      4'd3:  seg = 7'b0000110;
      4'd4:  seg = 7'b1001100;
      4'd5:  seg = 7'b0100100;
      4'd6:  seg = 7'b0100000;
      4'd7:  seg = 7'b0001111;
      4'd8:  seg = 7'b0000000;
      4'd9:  seg = 7'b0000100;
`ifdef SEG_LETTERS_EN
      4'd10: seg = 7'b0001000;
      4'd11: seg = 7'b1100000;
      4'd12: seg = 7'b0110001;
      4'd13: seg = 7'b0011000;
      4'd14: seg = 7'b0100100;
      4'd15: seg = 7'b1111110;
`else
      default: seg = 7'b1111110;
`endif
    endcase
  end

  assign bus.DISPLAY  = seg;
  assign bus.CLK_1KHz = wave_1k;
  assign bus.CLK_2Hz  = wave_2;
  assign bus.CLK_1Hz  = wave_1;

endmodule

// File: tb/tb_seg_decode_clkgen.sv
// Randomized self-checking bench: decoder vs. pattern table, dividers vs. edge-count arithmetic.
module tb_seg_decode_clkgen;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   edgeCount = 0;
  int   checkCount = 0;
  int   errorCount = 0;
  logic [6:0] segTable [16];

  seg_decode_clkgen_if bus();
  seg_decode_clkgen_if busFast();

  seg_decode_clkgen #(.CLK_HZ(4000)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  seg_decode_clkgen #(.CLK_HZ(20000)) dutFast (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (busFast)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edgeCount, got, exp);
    end
  endtask

  // Square wave with half-period h, observed after k edges since reset release.
  function automatic logic expWave(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction

  task automatic checkDecode(input logic [3:0] code);
    bus.BCD = code;
    busFast.BCD = code;
    #1;
    checkOutput($sformatf("display_%0d", code), 32'(bus.DISPLAY), 32'(segTable[code]));
    checkOutput($sformatf("display_fast_%0d", code), 32'(busFast.DISPLAY), 32'(segTable[code]));
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      edgeCount++;
      #1;
      checkOutput("clk_1khz", 32'(bus.CLK_1KHz), 32'(expWave(edgeCount, 2)));
      checkOutput("clk_2hz",  32'(bus.CLK_2Hz),  32'(expWave(edgeCount, 1000)));
      checkOutput("clk_1hz",  32'(bus.CLK_1Hz),  32'(expWave(edgeCount, 2000)));
      checkOutput("fast_1khz", 32'(busFast.CLK_1KHz), 32'(expWave(edgeCount, 10)));
      checkOutput("fast_2hz",  32'(busFast.CLK_2Hz),  32'(expWave(edgeCount, 5000)));
      checkDecode(4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    segTable[0] = 7'b0000001;  segTable[1] = 7'b1001111;
    segTable[2] = 7'b0010010;  segTable[3] = 7'b0000110;
    segTable[4] = 7'b1001100;  segTable[5] = 7'b0100100;
    segTable[6] = 7'b0100000;  segTable[7] = 7'b0001111;
    segTable[8] = 7'b0000000;  segTable[9] = 7'b0000100;
`ifdef SEG_LETTERS_EN
    segTable[10] = 7'b0001000; segTable[11] = 7'b1100000;
    segTable[12] = 7'b0110001; segTable[13] = 7'b0011000;
    segTable[14] = 7'b0100100; segTable[15] = 7'b1111110;
`else
    for (int i = 10; i < 16; i++) segTable[i] = 7'b1111110;
`endif

    bus.BCD = 4'd0;
    busFast.BCD = 4'd0;

    // Decoder works while the dividers are held in reset.
    for (int c = 0; c < 16; c++) checkDecode(4'(c));

    repeat (10) @(posedge CLK);
    #1;
    checkOutput("reset_1khz", 32'(bus.CLK_1KHz), 32'd0);
    checkOutput("reset_2hz",  32'(bus.CLK_2Hz),  32'd0);
    checkOutput("reset_1hz",  32'(bus.CLK_1Hz),  32'd0);
    #2 RST_N = 1'b1;
    edgeCount = 0;

    applyStimulus(1500);
    checkOutput("pre_reset_2hz_high", 32'(bus.CLK_2Hz), 32'd1);

    #1 RST_N = 1'b0;
    #1;
    checkOutput("async_reset_2hz",  32'(bus.CLK_2Hz),  32'd0);
    checkOutput("async_reset_1khz", 32'(bus.CLK_1KHz), 32'd0);
    checkOutput("async_reset_1hz",  32'(bus.CLK_1Hz),  32'd0);
    checkOutput("async_reset_fast", 32'(busFast.CLK_1KHz), 32'd0);

    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b1;
    edgeCount = 0;

    applyStimulus(2100);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
